// File: rtl/video_to_axis_bridge_pkg.sv
// rtl/video_to_axis_bridge_pkg.sv - shared stream widths, FIFO entry layout and FSM encodings
package video_to_axis_bridge_pkg;

  localparam int PIX_W     = 24;
  localparam int ISP_CNT_W = 16;

  // Flag offsets above the pixel payload inside a FIFO entry: {tuser, tlast, data}
  localparam int ENT_TLAST = 0;
  localparam int ENT_TUSER = 1;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - synchronous first-word-fall-through FIFO with zeroed output when empty
module axis_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_fire, rd_fire;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A write into a full FIFO is accepted when a read frees a slot in the same cycle
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_to_axis_bridge.sv
// rtl/video_to_axis_bridge.sv - camera timing to AXI4-Stream bridge; VIDEO_TO_AXIS_STATS_EN adds frame stats
module video_to_axis_bridge
  import video_to_axis_bridge_pkg::*;
#(
  parameter int DATA_W     = PIX_W,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = ISP_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vsync,
  input  logic              in_hsync,
  input  logic              in_den,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              ovf_sticky
`ifdef VIDEO_TO_AXIS_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_px_per_line,
  output logic [CNT_W-1:0]  stat_lines,
  output logic              stat_valid
`endif
);

  localparam int ENT_W = DATA_W + 2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            state, state_nxt;
  logic              vsync_q, vsync_rise;
  logic              pend_valid, pend_tuser;
  logic [DATA_W-1:0] pend_data;
  logic              push_req, push_tlast, pend_load, pend_clear;
  logic              pop, ovf, push_ok;
  logic              fifo_full, fifo_empty;
  logic [ENT_W-1:0]  push_entry, pop_entry;

  // Line end is only known lazily, so hsync carries no information here
  wire unused_ok = &{1'b0, in_hsync};

  assign vsync_rise = in_vsync && !vsync_q;
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign ovf        = push_req && fifo_full && !pop;
  assign push_ok    = push_req && !ovf;
  assign push_entry = {pend_tuser, push_tlast, pend_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WAIT_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ovf)                                 state_nxt = ST_DROP;
    else if (vsync_rise)                     state_nxt = ST_ARMED;
    else if (state == ST_ARMED && in_den)    state_nxt = ST_ACTIVE;
  end

  // A frame edge closes any open line before den is considered
  always_comb begin
    push_req   = 1'b0;
    push_tlast = 1'b0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    if (vsync_rise) begin
      push_req   = pend_valid;
      push_tlast = 1'b1;
      pend_clear = 1'b1;
    end else if (state == ST_ARMED || state == ST_ACTIVE) begin
      if (in_den) begin
        push_req  = pend_valid;
        pend_load = 1'b1;
      end else if (pend_valid) begin
        push_req   = 1'b1;
        push_tlast = 1'b1;
        pend_clear = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      pend_valid <= 1'b0;
      pend_tuser <= 1'b0;
      pend_data  <= '0;
      drop_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      vsync_q <= in_vsync;
      if (ovf) begin
        pend_valid <= 1'b0;
        ovf_sticky <= 1'b1;
        drop_cnt   <= sat_inc(drop_cnt);
      end else if (pend_load) begin
        pend_valid <= 1'b1;
        pend_tuser <= (state == ST_ARMED);
        pend_data  <= in_data;
      end else if (pend_clear) begin
        pend_valid <= 1'b0;
      end
    end
  end

  axis_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_ok),
    .wr_data (push_entry),
    .full    (fifo_full),
    .rd_en   (m_axis_tready),
    .rd_data (pop_entry),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = pop_entry[DATA_W-1:0];
  assign m_axis_tlast  = pop_entry[DATA_W+ENT_TLAST];
  assign m_axis_tuser  = pop_entry[DATA_W+ENT_TUSER];

`ifdef VIDEO_TO_AXIS_STATS_EN
  logic [CNT_W-1:0] px_cnt, line_cnt, last_len;
  logic             line_done;

  assign line_done = push_ok && push_tlast;

  // A line closed by the vsync edge itself still belongs to the finishing frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_cnt           <= '0;
      line_cnt         <= '0;
      last_len         <= '0;
      stat_px_per_line <= '0;
      stat_lines       <= '0;
      stat_valid       <= 1'b0;
    end else begin
      stat_valid <= vsync_rise;
      if (vsync_rise) begin
        stat_px_per_line <= line_done ? sat_inc(px_cnt) : last_len;
        stat_lines       <= line_done ? sat_inc(line_cnt) : line_cnt;
        px_cnt           <= '0;
        line_cnt         <= '0;
        last_len         <= '0;
      end else if (push_ok) begin
        if (push_tlast) begin
          last_len <= sat_inc(px_cnt);
          line_cnt <= sat_inc(line_cnt);
          px_cnt   <= '0;
        end else begin
          px_cnt <= sat_inc(px_cnt);
        end
      end
    end
  end
`endif

endmodule
